// File: rtl/dl_tdc_ctrl_pkg.sv
// dl_pkg: shared types and width helpers for the delay-line TDC controller.
//   dl_state_e  - controller FSM states
//   cnt_w()     - bits needed to hold a tap count 0..TAPS
//   acc_w()     - accumulator width: count width plus averaging headroom
//   clog2_min1()- select width that never collapses to zero bits
package dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ENCODE,
    ST_ACCUM,
    ST_DONE
  } dl_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int taps);
    return $clog2(taps + 1);
  endfunction

  function automatic int acc_w(input int taps, input int avg_log2);
    return cnt_w(taps) + avg_log2;
  endfunction

endpackage

// File: rtl/dl_therm_encode.sv
// dl_therm_encode: combinational thermometer decoder for one delay chain.
//   norm   - normalised tap snapshot (1 = edge has passed), tap 0 = LSB
//   count  - run length of 1s starting at tap 0 (0..TAPS)
//   bubble - a 1 exists above the first 0 (metastable or glitched tap)
module dl_therm_encode
  import dl_pkg::*;
#(
  parameter  int TAPS  = 32,
  localparam int CNT_W = cnt_w(TAPS)
) (
  input  logic [TAPS-1:0]  norm,
  output logic [CNT_W-1:0] count,
  output logic             bubble
);

  logic w_seen0;

  always_comb begin
    count   = '0;
    bubble  = 1'b0;
    w_seen0 = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (!norm[i])
        w_seen0 = 1'b1;
      else if (w_seen0)
        bubble = 1'b1;
      else
        count = count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dl_tdc_ctrl.sv
// dl_tdc_ctrl: launches an edge into one delay chain, snapshots its taps
// cfg_wait+1 clocks later, decodes the thermometer code and averages the
// tap count over 2^AVG_LOG2 launches.
//   clk, rst      - clock, synchronous active-high reset
//   start         - measurement request, honoured only when idle
//   cfg_ch        - chain select (out of range folds to chain 0)
//   cfg_wait      - extra clocks between launch and capture
//   taps_in       - all chains' taps, chain c at [c*TAPS +: TAPS]
//   launch        - per-chain launch level (registered)
//   busy          - measurement in progress
//   result_valid  - one-cycle pulse with result/result_bubble/result_sat
module dl_tdc_ctrl
  import dl_pkg::*;
#(
  parameter  int TAPS     = 32,
  parameter  int CHANNELS = 4,
  parameter  int WAIT_W   = 4,
  parameter  int AVG_LOG2 = 2,
  localparam int CNT_W    = cnt_w(TAPS),
  localparam int CH_W     = clog2_min1(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [WAIT_W-1:0]        cfg_wait,
  input  logic [CHANNELS*TAPS-1:0] taps_in,
  output logic [CHANNELS-1:0]      launch,
  output logic                     busy,
  output logic                     result_valid,
  output logic [CNT_W-1:0]         result,
  output logic                     result_bubble,
  output logic                     result_sat
);

  localparam int ACC_W = acc_w(TAPS, AVG_LOG2);
  localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  dl_state_e r_state, w_next;

  logic [CH_W-1:0]     r_ch;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_pol;
  logic [TAPS-1:0]     r_cap;
  logic [CNT_W-1:0]    r_count;
  logic                r_bubble_q;
  logic [ACC_W-1:0]    r_acc;
  logic                r_bubble;
  logic                r_sat;
  logic [SMP_W-1:0]    r_smp;
  logic [CHANNELS-1:0] r_launch;
  logic [CNT_W-1:0]    r_result;
  logic                r_res_bubble;
  logic                r_res_sat;
  logic                r_valid;

  logic [CHANNELS-1:0][TAPS-1:0] w_taps;
  logic [CH_W-1:0]     w_ch_sel;
  logic [TAPS-1:0]     w_norm;
  logic [CNT_W-1:0]    w_count;
  logic                w_bubble;
  logic                w_last;
  logic                w_sat_q;
  logic [ACC_W-1:0]    w_acc_sum;

  assign w_taps = taps_in;

  always_comb begin
    w_ch_sel = cfg_ch;
    if (int'(cfg_ch) >= CHANNELS)
      w_ch_sel = '0;
  end

  // Odd launches drive the chain high, even ones low; flip the snapshot so
  // the encoder always sees 1 = "edge has passed this tap".
  assign w_norm    = r_pol ? r_cap : ~r_cap;
  assign w_last    = (r_smp == SMP_W'((1 << AVG_LOG2) - 1));
  assign w_sat_q   = (r_count == CNT_W'(TAPS));
  assign w_acc_sum = r_acc + ACC_W'(r_count);

  dl_therm_encode #(.TAPS(TAPS)) u_enc (
    .norm   (w_norm),
    .count  (w_count),
    .bubble (w_bubble)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_WAIT;
      ST_WAIT:   if (r_wait_cnt == '0) w_next = ST_ENCODE;
      ST_ENCODE: w_next = ST_ACCUM;
      ST_ACCUM:  w_next = w_last ? ST_DONE : ST_WAIT;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch         <= '0;
      r_wait       <= '0;
      r_wait_cnt   <= '0;
      r_pol        <= 1'b0;
      r_cap        <= '0;
      r_count      <= '0;
      r_bubble_q   <= 1'b0;
      r_acc        <= '0;
      r_bubble     <= 1'b0;
      r_sat        <= 1'b0;
      r_smp        <= '0;
      r_launch     <= '0;
      r_result     <= '0;
      r_res_bubble <= 1'b0;
      r_res_sat    <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_ch               <= w_ch_sel;
          r_wait             <= cfg_wait;
          r_wait_cnt         <= cfg_wait;
          r_launch[w_ch_sel] <= ~r_launch[w_ch_sel];
          r_pol              <= ~r_launch[w_ch_sel];
          r_acc              <= '0;
          r_bubble           <= 1'b0;
          r_sat              <= 1'b0;
          r_smp              <= '0;
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0)
            r_cap <= w_taps[r_ch];
          else
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
        end
        ST_ENCODE: begin
          r_count    <= w_count;
          r_bubble_q <= w_bubble;
        end
        ST_ACCUM: begin
          r_acc    <= w_acc_sum;
          r_bubble <= r_bubble | r_bubble_q;
          r_sat    <= r_sat | w_sat_q;
          if (w_last) begin
            // Load the result here so it is already stable during DONE.
            r_result     <= CNT_W'(w_acc_sum >> AVG_LOG2);
            r_res_bubble <= r_bubble | r_bubble_q;
            r_res_sat    <= r_sat | w_sat_q;
            r_valid      <= 1'b1;
          end else begin
            r_launch[r_ch] <= ~r_launch[r_ch];
            r_pol          <= ~r_launch[r_ch];
            r_wait_cnt     <= r_wait;
            r_smp          <= r_smp + SMP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign launch        = r_launch;
  assign busy          = (r_state != ST_IDLE);
  assign result_valid  = r_valid;
  assign result        = r_result;
  assign result_bubble = r_res_bubble;
  assign result_sat    = r_res_sat;

endmodule

// File: tb/tb_dl_tdc_ctrl.sv
// Directed bench: u_dut0 single-shot (AVG_LOG2=0), u_dut2 4-sample average.
module tb_dl_tdc_ctrl;

  localparam int TAPS = 32;
  localparam int CH   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start0, start2;
  logic [1:0]        cfg_ch;
  logic [3:0]        cfg_wait;
  logic [CH*TAPS-1:0] taps_in;
  logic [CH-1:0]     launch0, launch2;
  logic              busy0, busy2, val0, val2;
  logic [5:0]        res0, res2;
  logic              bub0, bub2, sat0, sat2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dl_tdc_ctrl #(.TAPS(TAPS), .CHANNELS(CH), .WAIT_W(4), .AVG_LOG2(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .cfg_ch(cfg_ch), .cfg_wait(cfg_wait),
    .taps_in(taps_in), .launch(launch0), .busy(busy0), .result_valid(val0),
    .result(res0), .result_bubble(bub0), .result_sat(sat0));

  dl_tdc_ctrl #(.TAPS(TAPS), .CHANNELS(CH), .WAIT_W(4), .AVG_LOG2(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .cfg_ch(cfg_ch), .cfg_wait(cfg_wait),
    .taps_in(taps_in), .launch(launch2), .busy(busy2), .result_valid(val2),
    .result(res2), .result_bubble(bub2), .result_sat(sat2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_taps(input int ch, input logic [31:0] v);
    taps_in[ch*TAPS +: TAPS] = v;
  endtask

  // Returns at the negedge of cycle T+1 (T = cycle start is high).
  task automatic go(input int d, input int ch, input int w);
    @(negedge clk);
    cfg_ch   = 2'(ch);
    cfg_wait = 4'(w);
    if (d == 0) start0 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  function automatic logic vld(input int d);
    return (d == 0) ? val0 : val2;
  endfunction

  // lat = current cycle offset from T; bounded wait for result_valid.
  task automatic wait_result(input int d, input string tag, input int lat0, input int exp_lat);
    int lat;
    lat = lat0;
    while (!vld(d) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  logic [31:0] pat [4];
  int toggles, vcnt, vc;
  logic prev;

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
    cfg_ch = '0; cfg_wait = '0; taps_in = '0;
    pat[0] = 32'h0000_000F; pat[1] = 32'hFFFF_FFE0;
    pat[2] = 32'h0000_003F; pat[3] = 32'hFFFF_FF80;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_launch0", 64'(launch0), 64'h0);
    chk("rst_busy0",   64'(busy0),   64'h0);
    chk("rst_valid0",  64'(val0),    64'h0);
    chk("rst_result0", {58'h0, res0, bub0, sat0}, 64'h0);
    chk("rst_result2", {launch2, busy2, val2, res2, bub2, sat2}, 64'h0);
    rst = 1'b0;

    // single shot, ch1, pol=1
    set_taps(1, 32'h0000_00FF);
    go(0, 1, 0);
    chk("t1_launch", 64'(launch0), 64'h2);
    chk("t1_busy",   64'(busy0),   64'h1);
    wait_result(0, "t1", 1, 4);
    chk("t1_res", {res0, bub0, sat0}, {6'd8, 1'b0, 1'b0});

    // second launch on ch1 falls, snapshot inverted
    set_taps(1, 32'hFFFF_FC00);
    go(0, 1, 0);
    chk("t2_launch", 64'(launch0), 64'h0);
    wait_result(0, "t2", 1, 4);
    chk("t2_res", {res0, bub0, sat0}, {6'd10, 1'b0, 1'b0});

    // bubble
    set_taps(1, 32'h0000_F00F);
    go(0, 1, 0);
    chk("t3_launch", 64'(launch0), 64'h2);
    wait_result(0, "t3", 1, 4);
    chk("t3_res", {res0, bub0, sat0}, {6'd4, 1'b1, 1'b0});

    // saturation on ch3
    set_taps(3, 32'hFFFF_FFFF);
    go(0, 3, 0);
    chk("t4_launch", 64'(launch0), 64'hA);
    wait_result(0, "t4", 1, 4);
    chk("t4_res", {res0, bub0, sat0}, {6'd32, 1'b0, 1'b1});

    // start/cfg changes while busy are ignored
    set_taps(1, 32'hFFFF_FFF8);
    go(0, 1, 2);
    chk("t5_launch", 64'(launch0), 64'h8);
    cfg_ch = 2'd3; cfg_wait = 4'd0; start0 = 1'b1; set_taps(3, 32'h0);
    @(negedge clk);
    start0 = 1'b0;
    chk("t5_launch_mid", 64'(launch0), 64'h8);
    wait_result(0, "t5", 2, 6);
    chk("t5_res", {res0, bub0, sat0}, {6'd3, 1'b0, 1'b0});
    @(negedge clk);
    chk("t5_after", {launch0, busy0, val0}, {4'h8, 1'b0, 1'b0});

    // 4-sample average on ch2, cfg_wait=3, taps swapped per launch
    set_taps(2, pat[0]);
    prev = launch2[2];
    go(2, 2, 3);
    toggles = 0; vcnt = 0; vc = 0;
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) @(negedge clk);
      if ((c - 1) % 6 == 0 && (c - 1) / 6 < 4) set_taps(2, pat[(c - 1) / 6]);
      if (launch2[2] !== prev) begin toggles++; prev = launch2[2]; end
      if (val2) begin vcnt++; vc = c; end
    end
    chk("avg_toggles", 64'(toggles), 64'd4);
    chk("avg_vcycle",  64'(vc),      64'd25);
    chk("avg_vcount",  64'(vcnt),    64'd1);
    chk("avg_res", {res2, bub2, sat2}, {6'd5, 1'b0, 1'b0});

    // reset during WAIT aborts
    set_taps(0, 32'h0000_FFFF);
    go(2, 0, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {launch2, busy2, val2, res2, launch0}, 64'h0);
    rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (val2) vcnt++;
    end
    chk("rst_mid_novalid", 64'(vcnt), 64'd0);
    go(2, 0, 0);
    chk("rst_fresh_launch", 64'(launch2), 64'h1);
    wait_result(2, "rst_fresh", 1, 13);
    chk("rst_fresh_res", {res2, bub2, sat2}, {6'd8, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
